// File: rtl/rf_fifo_ctrl.sv
// rf_fifo_ctrl: FIFO control logic using an external 2R/1W register_file as storage.
// Latency: push is written at the accepting edge; accepted pop gives dout/dout_valid 1 clk later.
// Backpressure: none; a rejected push (full) pulses ovf, a rejected pop (empty) pulses udf.
//
// Optional build macro RF_FIFO_EDGE_DETECT_EN: treat en_in/en_out as level inputs and
// fire one request per rising edge. Undefined: every high cycle is a request.
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   en_in, din            push request and push data
//   en_out                pop request
//   dout, dout_valid      registered pop data and its one-cycle valid pulse
//   count, full, empty    occupancy 0..DEPTH and derived status
//   ovf, udf              one-cycle pulses for rejected push / rejected pop
//   rf_we, rf_wa, rf_wd   register_file write port
//   rf_ra, rf_rd          register_file read port 0 (combinational read)
module rf_fifo_ctrl #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_in,
  input  logic [WIDTH-1:0]  din,
  input  logic              en_out,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              udf,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [WIDTH-1:0]  rf_wd,
  output logic [ADDR_W-1:0] rf_ra,
  input  logic [WIDTH-1:0]  rf_rd
);

  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE = 1;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_req;
  logic              pop_req;
  logic              push_ok;
  logic              pop_ok;

`ifdef RF_FIFO_EDGE_DETECT_EN
  logic en_in_q;
  logic en_out_q;

  // Previous-value registers reset to 0, so an input already high on the
  // first cycle after reset is seen as a rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_in_q  <= 1'b0;
      en_out_q <= 1'b0;
    end else begin
      en_in_q  <= en_in;
      en_out_q <= en_out;
    end
  end

  assign push_req = en_in && !en_in_q;
  assign pop_req  = en_out && !en_out_q;
`else
  assign push_req = en_in;
  assign pop_req  = en_out;
`endif

  // count never exceeds DEPTH, so its MSB is set only when exactly full.
  assign full  = count[ADDR_W];
  assign empty = (count == '0);

  assign pop_ok  = pop_req && !empty;
  // A push into a full FIFO is fine when a pop frees the slot at the same edge:
  // the pop samples rf_rd before the register file commits the write.
  assign push_ok = push_req && (!full || pop_ok);

  assign rf_we = push_ok && rst_n;
  assign rf_wa = wr_ptr;
  assign rf_wd = din;
  assign rf_ra = rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      ovf        <= 1'b0;
      udf        <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        dout   <= rf_rd;
      end
      dout_valid <= pop_ok;

      if (push_ok && !pop_ok) begin
        count <= count + CNT_ONE;
      end else if (pop_ok && !push_ok) begin
        count <= count - CNT_ONE;
      end

      ovf <= push_req && !push_ok;
      udf <= pop_req && empty;
    end
  end

endmodule

// File: doc/rf_fifo_ctrl.md
Name: rf_fifo_ctrl

Overview:
- FIFO controller that uses the team's register_file (2 async read ports, 1 sync write port) as its storage array.
- Sits directly upstream of register_file: drives its write port (wa/we/wd) and read address (ra0), and consumes rd0.
- Provides push/pop handshakes, occupancy count, full/empty status, overflow/underflow pulses and a registered pop output.

Parameters:
- WIDTH, 32, data width; must match the register_file width parameter.
- ADDR_W, 3, pointer width; DEPTH = 2**ADDR_W entries; legal range 1..5. Integrator zero-extends rf_wa/rf_ra to 5 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- en_in  in  1  push request.
- din  in  WIDTH  push data.
- en_out  in  1  pop request.
- dout  out  WIDTH  popped data, registered.
- dout_valid  out  1  one-cycle pulse; dout updated this cycle.
- count  out  ADDR_W+1  occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- ovf  out  1  one-cycle pulse; push rejected.
- udf  out  1  one-cycle pulse; pop rejected.
- rf_we  out  1  to register_file we.
- rf_wa  out  ADDR_W  to register_file wa.
- rf_wd  out  WIDTH  to register_file wd.
- rf_ra  out  ADDR_W  to register_file ra0.
- rf_rd  in  WIDTH  from register_file rd0, combinational read.

Behaviour:
- Reset (rst_n low at a clk edge): wr_ptr=0, rd_ptr=0, count=0, dout=0, dout_valid=0, ovf=0, udf=0. full=0 and empty=1, both derived from count. Reset overrides any push or pop in the same cycle. A push asserted during reset is not written: rf_we=0 while rst_n=0.
- push_req is en_in; pop_req is en_out (see Optional Feature).
- pop_ok = pop_req && !empty.
- push_ok = push_req && (!full || pop_ok). Push while full is allowed only together with an accepted pop.
- Write path, combinational:
  - rf_we = push_ok && rst_n
  - rf_wa = wr_ptr
  - rf_wd = din
  - The register file commits the write at the same edge.
- Read path: rf_ra = rd_ptr, combinational. On pop_ok: dout <= rf_rd and dout_valid <= 1. Otherwise dout holds and dout_valid <= 0. Latency is 1 cycle from accepted pop to dout_valid.
- Pointers: wr_ptr += 1 on push_ok; rd_ptr += 1 on pop_ok. Both wrap modulo DEPTH (natural ADDR_W overflow).
- Count rules:
  - push_ok only: count+1
  - pop_ok only: count-1
  - both: unchanged
- Simultaneous push+pop when full: both accepted. The pop reads the old entry at rd_ptr before the same-edge write, so wr_ptr==rd_ptr is safe.
- Simultaneous push+pop when empty: pop rejected (udf=1), push accepted, count becomes 1. There is no bypass from din to dout.
- ovf <= push_req && !push_ok. udf <= push_req-independent: pop_req && empty. Both are registered, one cycle.
- Stored data is never cleared by reset; only the pointers are cleared.

Optional Feature:
- Macro: RF_FIFO_EDGE_DETECT_EN.
- Defined:
  - en_in and en_out are level inputs, e.g. debounced buttons.
  - Previous-value registers (reset to 0) give push_req = en_in && !en_in_q and pop_req = en_out && !en_out_q. A request therefore fires once per rising edge, however long the input is held.
  - Input high on the first cycle after reset counts as an edge.
- Undefined: push_req = en_in and pop_req = en_out on every cycle they are high. No extra registers.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with en_in=1, din=123 -> rf_we=0, count=0, empty=1, full=0, dout=0, no pulses.
- Fill/overflow: push 8 values 11..18 on consecutive cycles, then push 99 -> count=8, full=1; 9th push gives ovf pulse, count stays 8, rf_we=0 that cycle.
- Drain/order/underflow: pop 9 times -> dout=11..18, each with dout_valid one cycle after its pop; count reaches 0, empty=1; 9th pop gives udf pulse and dout stays 18.
- Wrap: push 5 and pop 5 (values 1..5), then push 6 values 100..105 -> rf_wa sequence 5,6,7,0,1,2; pops return 100..105 in order.
- Simultaneous ops: when full (values 21..28), push 77 together with a pop -> dout=21, count=8, later pops end with 77. When empty, push 5 together with a pop -> udf=1, count=1, next pop returns 5.
- Edge detect (macro defined): hold en_in=1 for 4 cycles with din=42 -> exactly one write, count=1. Without the macro the same stimulus gives count=4.
